// File: rtl/tileng_prep_sched.sv
// Per-scanline scheduler: preps the BG then the FG tile engine for each accepted row and
// muxes their VRAM read addresses. Optional watchdog on engine waits: TILESCHED_WATCHDOG_EN.
module tileng_prep_sched #(
    parameter int VISIBLE_ROWS   = 240,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [7:0]  next_row,
    output logic [7:0]  row_q,
    output logic        bg_prep,
    output logic        fg_prep,
    input  logic        bg_done,
    input  logic        fg_done,
    input  logic [10:0] bg_tilram_addr,
    input  logic [10:0] fg_tilram_addr,
    input  logic [11:0] bg_patram_addr,
    input  logic [11:0] fg_patram_addr,
    output logic [10:0] tilram_addr,
    output logic [11:0] patram_addr,
    output logic        line_ready,
    output logic        busy,
    output logic        overrun,
    output logic        timeout,
    input  logic        clr_flags
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BG_PREP = 3'd1,
        BG_WAIT = 3'd2,
        FG_PREP = 3'd3,
        FG_WAIT = 3'd4
    } state_t;

    localparam logic [7:0] VIS_ROWS_C = 8'(VISIBLE_ROWS);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  row_q_r;
    logic        sel_fg_r;
    logic        bg_prep_r;
    logic        fg_prep_r;
    logic        line_ready_r;
    logic        busy_r;
    logic        overrun_r;
    logic        overrun_set_s;
    logic        wd_exp_s;

`ifdef TILESCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LAST_C = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_r;
    logic        timeout_r;

    // A wait expires when it has lasted TIMEOUT_CYCLES cycles and its done is still absent.
    assign wd_exp_s = (wd_cnt_r == WD_LAST_C) &&
                      (((state_r == BG_WAIT) && !bg_done) ||
                       ((state_r == FG_WAIT) && !fg_done));

    // Wait-cycle counter: zeroed on entry to each WAIT state, counts while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= 16'd0;
        end else if (((state_nxt_s == BG_WAIT) || (state_nxt_s == FG_WAIT)) &&
                     (state_nxt_s != state_r)) begin
            wd_cnt_r <= 16'd0;
        end else if ((state_r == BG_WAIT) || (state_r == FG_WAIT)) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Sticky timeout flag; a firing watchdog beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_r <= 1'b0;
        end else if (wd_exp_s) begin
            timeout_r <= 1'b1;
        end else if (clr_flags) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout = timeout_r;
`else
    assign wd_exp_s = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Next-state logic for the BG-then-FG prep sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (line_start && (next_row < VIS_ROWS_C)) begin
                    state_nxt_s = BG_PREP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BG_PREP: state_nxt_s = BG_WAIT;
            BG_WAIT: begin
                if (bg_done || wd_exp_s) begin
                    state_nxt_s = FG_PREP;
                end else begin
                    state_nxt_s = BG_WAIT;
                end
            end
            FG_PREP: state_nxt_s = FG_WAIT;
            FG_WAIT: begin
                if (fg_done || wd_exp_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FG_WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    assign overrun_set_s = line_start && (state_r != IDLE);

    // State register and outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            bg_prep_r    <= 1'b0;
            fg_prep_r    <= 1'b0;
            busy_r       <= 1'b0;
            sel_fg_r     <= 1'b0;
            line_ready_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            bg_prep_r    <= (state_nxt_s == BG_PREP);
            fg_prep_r    <= (state_nxt_s == FG_PREP);
            busy_r       <= (state_nxt_s != IDLE);
            sel_fg_r     <= (state_nxt_s == FG_PREP) || (state_nxt_s == FG_WAIT);
            line_ready_r <= (state_r == FG_WAIT) && (state_nxt_s == IDLE);
        end
    end

    // Row latch: any line_start seen in IDLE is captured, even rows that are not prepped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q_r <= 8'd0;
        end else if (line_start && (state_r == IDLE)) begin
            row_q_r <= next_row;
        end else begin
            row_q_r <= row_q_r;
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (overrun_set_s) begin
            overrun_r <= 1'b1;
        end else if (clr_flags) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign tilram_addr = sel_fg_r ? fg_tilram_addr : bg_tilram_addr;
    assign patram_addr = sel_fg_r ? fg_patram_addr : bg_patram_addr;

    assign row_q      = row_q_r;
    assign bg_prep    = bg_prep_r;
    assign fg_prep    = fg_prep_r;
    assign line_ready = line_ready_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;

endmodule
